// File: rtl/grad_mag_sqr.sv
`default_nettype none
// ============================================================================
//  Module      : grad_mag_sqr
//  Description : Serial shift-add magnitude-squared unit, gx^2 + gy^2.
//  Revision    : 1.0 - initial release
// ============================================================================
module grad_mag_sqr #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   abort,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [IN_W-1:0] gx,
   input  logic signed [IN_W-1:0] gy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_W-1:0]       out_data,
   output logic                   busy
);

   localparam int                CNT_W      = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(IN_W - 1);
   localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
   localparam logic [IN_W-1:0]   C_ONE      = IN_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SQ_X = 2'd1,
      S_SQ_Y = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [OUT_W-1:0]  r_acc;
   logic [OUT_W-1:0]  r_mcand;
   logic [IN_W-1:0]   r_mplier;
   logic [IN_W-1:0]   r_absy;
   logic [CNT_W-1:0]  r_cnt;
   logic [OUT_W-1:0]  r_out;

   logic [IN_W-1:0]   w_absx;
   logic [IN_W-1:0]   w_absy;
   logic [OUT_W-1:0]  w_addend;
   logic [OUT_W-1:0]  w_acc_nxt;
   logic              w_last;

   // Unsigned IN_W result holds 2^(IN_W-1), so the most negative input is exact.
   assign w_absx    = gx[IN_W-1] ? (~unsigned'(gx) + C_ONE) : unsigned'(gx);
   assign w_absy    = gy[IN_W-1] ? (~unsigned'(gy) + C_ONE) : unsigned'(gy);
   assign w_addend  = r_mplier[0] ? r_mcand : '0;
   assign w_acc_nxt = r_acc + w_addend;
   assign w_last    = (r_cnt == C_CNT_LAST);

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign out_data  = r_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_SQ_X;
            S_SQ_X:  if (w_last)    w_state_nxt = S_SQ_Y;
            S_SQ_Y:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_absy   <= '0;
         r_cnt    <= '0;
         r_out    <= '0;
      end else if (abort) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_out <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mcand  <= {{(OUT_W-IN_W){1'b0}}, w_absx};
                  r_mplier <= w_absx;
                  r_absy   <= w_absy;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            S_SQ_X: begin
               r_acc <= w_acc_nxt;
               if (w_last) begin
                  // Accumulator carries gx^2 straight into the gy pass.
                  r_mcand  <= {{(OUT_W-IN_W){1'b0}}, r_absy};
                  r_mplier <= r_absy;
                  r_cnt    <= '0;
               end else begin
                  r_mcand  <= {r_mcand[OUT_W-2:0], 1'b0};
                  r_mplier <= {1'b0, r_mplier[IN_W-1:1]};
                  r_cnt    <= r_cnt + C_CNT_ONE;
               end
            end
            S_SQ_Y: begin
               r_acc    <= w_acc_nxt;
               r_mcand  <= {r_mcand[OUT_W-2:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[IN_W-1:1]};
               if (w_last) begin
                  r_cnt <= '0;
                  r_out <= w_acc_nxt;
               end else begin
                  r_cnt <= r_cnt + C_CNT_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_grad_mag_sqr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grad_mag_sqr
//  Description : Directed self-checking bench for grad_mag_sqr.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grad_mag_sqr;

   localparam int IN_W  = 16;
   localparam int OUT_W = 32;
   localparam int LAT   = 2 * IN_W;

   logic                   clk       = 1'b0;
   logic                   rst_n     = 1'b1;
   logic                   abort     = 1'b0;
   logic                   in_valid  = 1'b0;
   logic                   out_ready = 1'b0;
   logic signed [IN_W-1:0] gx        = '0;
   logic signed [IN_W-1:0] gy        = '0;
   logic                   in_ready;
   logic                   out_valid;
   logic                   busy;
   logic [OUT_W-1:0]       out_data;

   int                     n_cmp = 0;
   int                     n_err = 0;
   logic [OUT_W-1:0]       sb_q[$];

   grad_mag_sqr #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .gx        (gx),
      .gy        (gy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   function automatic logic [OUT_W-1:0] model(input logic signed [IN_W-1:0] a,
                                              input logic signed [IN_W-1:0] b);
      longint la = a;
      longint lb = b;
      return OUT_W'(la * la + lb * lb);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic signed [IN_W-1:0] x, input logic signed [IN_W-1:0] y,
                         input bit push);
      int k = 0;
      while (!in_ready && k < 100) begin
         step();
         k++;
      end
      chk1("ready_before_accept", in_ready, 1'b1);
      gx = x;
      gy = y;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (push) sb_q.push_back(model(x, y));
      chk1("busy_after_accept", busy, 1'b1);
   endtask

   task automatic run_op(input logic signed [IN_W-1:0] x, input logic signed [IN_W-1:0] y,
                         input int hold);
      logic [OUT_W-1:0] exp;
      out_ready = (hold == 0);
      accept(x, y, 1'b1);
      for (int k = 1; k < LAT; k++) begin
         step();
         chk1("no_early_valid", out_valid, 1'b0);
         chk1("busy_during_op", busy, 1'b1);
      end
      step();
      chk1("valid_at_latency", out_valid, 1'b1);
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL scoreboard: observed empty queue expected entry");
         exp = '0;
      end else begin
         exp = sb_q.pop_front();
      end
      for (int h = 0; h < hold; h++) begin
         chk1("hold_valid", out_valid, 1'b1);
         chk1("hold_not_ready", in_ready, 1'b0);
         chk("hold_data", out_data, exp);
         gx = 16'sd1;
         gy = 16'sd1;
         in_valid = 1'b1;
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("out_data", out_data, exp);
      step();
      chk1("ready_after_consume", in_ready, 1'b1);
      chk1("valid_after_consume", out_valid, 1'b0);
      chk1("idle_after_consume", busy, 1'b0);
      chk("data_kept", out_data, exp);
   endtask

   initial begin
      #2;
      rst_n = 1'b0;
      #1;
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk("rst_out_data", out_data, '0);
      step();
      step();
      rst_n = 1'b1;
      step();

      run_op(16'sd3, 16'sd4, 0);
      run_op(-16'sd32768, -16'sd32768, 0);
      run_op(-16'sd1, 16'sd32767, 0);
      run_op(16'sd0, 16'sd0, 0);
      run_op(-16'sd100, 16'sd200, 10);

      // Reset mid-operation discards the partial result.
      accept(16'sd1000, 16'sd1000, 1'b0);
      repeat (11) step();
      rst_n = 1'b0;
      #1;
      chk1("midrst_in_ready", in_ready, 1'b1);
      chk1("midrst_out_valid", out_valid, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      chk("midrst_out_data", out_data, '0);
      step();
      rst_n = 1'b1;
      step();
      run_op(16'sd5, 16'sd12, 0);

      // Abort mid-operation.
      accept(16'sd7, 16'sd7, 1'b0);
      repeat (19) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_in_ready", in_ready, 1'b1);
      chk1("abort_out_valid", out_valid, 1'b0);
      chk("abort_out_data", out_data, '0);
      for (int k = 0; k < LAT + 8; k++) begin
         step();
         chk1("abort_no_valid", out_valid, 1'b0);
      end

      // Abort wins over a simultaneous in_valid in IDLE.
      gx = 16'sd3;
      gy = 16'sd3;
      abort = 1'b1;
      in_valid = 1'b1;
      step();
      abort = 1'b0;
      in_valid = 1'b0;
      chk1("abort_vs_valid_busy", busy, 1'b0);
      step();
      chk1("abort_vs_valid_busy2", busy, 1'b0);

      run_op(16'sd12, -16'sd5, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
